// File: rtl/instruction_fetch.sv
// Instruction fetch front end: one outstanding instruction-memory read at a
// time, holds the returned word for decode, and follows branch/jump redirects.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | first cycle after reset, no request issued yet
// FETCH | request at the fetch pointer is outstanding
// HOLD  | instruction held for decode, no request outstanding
// FLUSH | stale request (pre-redirect address) outstanding, reply dropped
// HALT  | misaligned redirect seen, frozen until reset
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        IMem_Req_o,
  output logic [31:0] IMem_Addr_o,
  input  logic        IMem_Rsp_Valid_i,
  input  logic [31:0] IMem_Rsp_Data_i,
  input  logic        Stall_i,
  input  logic        Redirect_i,
  input  logic [31:0] Redirect_PC_i,
  output logic [31:0] Instr_o,
  output logic [6:0]  OP_o,
  output logic [31:0] PC_o,
  output logic        Instr_Valid_o,
  output logic        Misalign_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_o_q, pc_o_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic        redirect_bad;
  logic        redirect_ok;

  // A redirect target must be word aligned; a bad one stops the front end.
  assign redirect_bad = Redirect_i && (Redirect_PC_i[1:0] != 2'b00);
  assign redirect_ok  = Redirect_i && (Redirect_PC_i[1:0] == 2'b00);

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_o_d     = pc_o_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;

    if (state_q != HALT && redirect_bad) begin
      // PC is intentionally left alone; the held word is invalidated.
      misalign_d = 1'b1;
      valid_d    = 1'b0;
      state_d    = HALT;
    end else if (state_q != HALT && redirect_ok) begin
      pc_d    = Redirect_PC_i;
      valid_d = 1'b0;
      // A request still in flight must drain before the new address goes out.
      if ((state_q == FETCH || state_q == FLUSH) && !IMem_Rsp_Valid_i) begin
        state_d = FLUSH;
      end else begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (IMem_Rsp_Valid_i) begin
            instr_d = IMem_Rsp_Data_i;
            pc_o_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (!Stall_i) begin
            valid_d = 1'b0;
            state_d = FETCH;
          end
        end
        FLUSH: begin
          if (IMem_Rsp_Valid_i) begin
            state_d = FETCH;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Request/address are registered; a FLUSH keeps the old address on the bus.
  always_comb begin
    req_d  = (state_d == FETCH) || (state_d == FLUSH);
    addr_d = (state_d == FETCH) ? pc_d : addr_q;
  end

  // Single state register for the whole fetch FSM and its outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      instr_q    <= NOP;
      pc_o_q     <= RESET_PC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      instr_q    <= instr_d;
      pc_o_q     <= pc_o_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign IMem_Req_o    = req_q;
  assign IMem_Addr_o   = addr_q;
  assign Instr_o       = instr_q;
  assign OP_o          = instr_q[6:0];
  assign PC_o          = pc_o_q;
  assign Instr_Valid_o = valid_q;
  assign Misalign_o    = misalign_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the fetch behaviour.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        req;
  logic [31:0] addr;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] pc_o;
  logic        valid;
  logic        mis;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rsp;
  logic [31:0] w_instr;
  logic [6:0]  w_op;
  logic [31:0] w_pc;
  logic        w_valid;
  logic        w_mis;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: request/hold bookkeeping, not a state encoding.
  bit          m_idle, m_req, m_discard, m_have, m_halt, m_mis;
  logic [31:0] m_pc, m_addr, m_instr, m_pco;

  logic [31:0] wq[$];

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RST_PC)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .IMem_Req_o       (req),
    .IMem_Addr_o      (addr),
    .IMem_Rsp_Valid_i (rsp_valid),
    .IMem_Rsp_Data_i  (rsp_data),
    .Stall_i          (stall),
    .Redirect_i       (redirect),
    .Redirect_PC_i    (redirect_pc),
    .Instr_o          (instr),
    .OP_o             (op),
    .PC_o             (pc_o),
    .Instr_Valid_o    (valid),
    .Misalign_o       (mis)
  );

  // Zero-wait memory on a second instance that starts at the top of memory.
  assign w_rsp = w_req;

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk              (clk),
    .reset            (reset),
    .IMem_Req_o       (w_req),
    .IMem_Addr_o      (w_addr),
    .IMem_Rsp_Valid_i (w_rsp),
    .IMem_Rsp_Data_i  (32'h0000_0013),
    .Stall_i          (1'b0),
    .Redirect_i       (1'b0),
    .Redirect_PC_i    (32'h0000_0000),
    .Instr_o          (w_instr),
    .OP_o             (w_op),
    .PC_o             (w_pc),
    .Instr_Valid_o    (w_valid),
    .Misalign_o       (w_mis)
  );

  always @(negedge clk) begin
    if (!reset && w_req) wq.push_back(w_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit rv, input logic [31:0] rd,
                            input bit st, input bit rdir, input logic [31:0] rpc);
    if (rst) begin
      m_idle = 1; m_req = 0; m_discard = 0; m_have = 0; m_halt = 0; m_mis = 0;
      m_pc = RST_PC; m_addr = RST_PC; m_instr = 32'h0000_0013; m_pco = RST_PC;
    end else if (m_halt) begin
      // frozen
    end else if (rdir && (rpc % 4 != 0)) begin
      m_mis = 1; m_have = 0; m_halt = 1; m_req = 0; m_idle = 0;
    end else if (rdir) begin
      m_pc = rpc; m_have = 0; m_idle = 0;
      if (m_req && !rv) begin
        m_discard = 1;
      end else begin
        m_req = 1; m_discard = 0; m_addr = rpc;
      end
    end else if (m_idle) begin
      m_idle = 0; m_req = 1; m_addr = m_pc; m_discard = 0;
    end else if (m_req) begin
      if (rv) begin
        if (m_discard) begin
          m_discard = 0; m_addr = m_pc;
        end else begin
          m_instr = rd; m_pco = m_pc; m_have = 1; m_pc = m_pc + 32'd4; m_req = 0;
        end
      end
    end else if (!st) begin
      m_have = 0; m_req = 1; m_addr = m_pc;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] mi;
    mi = m_instr;
    check_eq("req", req, m_req);
    if (m_req) check_eq("addr", addr, m_addr);
    check_eq("valid", valid, m_have);
    check_eq("instr", instr, m_instr);
    check_eq("op", op, mi[6:0]);
    check_eq("pc_o", pc_o, m_pco);
    check_eq("misalign", mis, m_mis);
  endtask

  // One clock: compare at the falling edge, drive, then advance the model.
  task automatic step(input bit rst, input bit rv, input logic [31:0] rd,
                      input bit st, input bit rdir, input logic [31:0] rpc);
    check_outputs();
    reset = rst; rsp_valid = rv; rsp_data = rd; stall = st;
    redirect = rdir; redirect_pc = rpc;
    @(posedge clk);
    model_step(rst, rv, rd, st, rdir, rpc);
    @(negedge clk);
  endtask

  initial begin
    int halt_cnt;
    bit r_rst, r_rv, r_st, r_dir;
    logic [31:0] r_rd, r_rpc;
    int pick;

    reset = 1; rsp_valid = 0; rsp_data = 0; stall = 0; redirect = 0; redirect_pc = 0;
    repeat (2) @(posedge clk);
    model_step(1, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset release, zero-wait memory
    step(0, 0, 0, 0, 0, 0);
    check_eq("d_req_first", req, 1);
    check_eq("d_addr_first", addr, 32'h0040_0000);
    step(0, 1, 32'h0000_0033, 0, 0, 0);
    check_eq("d_valid_first", valid, 1);
    check_eq("d_op_first", op, 7'h33);
    check_eq("d_pc_first", pc_o, 32'h0040_0000);
    step(0, 0, 0, 0, 0, 0);
    check_eq("d_addr_second", addr, 32'h0040_0004);

    // Stall three cycles in HOLD
    step(0, 1, 32'h00A0_0093, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 0);
      check_eq("d_stall_req", req, 0);
      check_eq("d_stall_pc", pc_o, 32'h0040_0004);
      check_eq("d_stall_instr", instr, 32'h00A0_0093);
    end
    step(0, 0, 0, 0, 0, 0);
    check_eq("d_after_stall_addr", addr, 32'h0040_0008);

    // Wrap-around instance: second fetch address
    check_eq("d_wrap_count", (wq.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
    if (wq.size() >= 2) begin
      check_eq("d_wrap_first", wq[0], 32'hFFFF_FFFC);
      check_eq("d_wrap_second", wq[1], 32'h0000_0000);
    end
    check_eq("d_wrap_mis", w_mis, 0);

    // Redirect while a request waits
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0040_0100);
    check_eq("d_flush_req", req, 1);
    check_eq("d_flush_addr", addr, 32'h0040_0008);
    step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    check_eq("d_redir_addr", addr, 32'h0040_0100);
    check_eq("d_redir_valid", valid, 0);
    step(0, 1, 32'h0000_0513, 0, 0, 0);
    check_eq("d_redir_pc", pc_o, 32'h0040_0100);
    check_eq("d_redir_instr", instr, 32'h0000_0513);

    // Redirect and stall together in HOLD
    step(0, 0, 0, 1, 1, 32'h0040_0200);
    check_eq("d_rs_valid", valid, 0);
    check_eq("d_rs_req", req, 1);
    check_eq("d_rs_addr", addr, 32'h0040_0200);

    // Misaligned redirect halts until reset
    step(0, 0, 0, 0, 1, 32'h0040_0102);
    check_eq("d_mis_flag", mis, 1);
    check_eq("d_mis_req", req, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 32'h0040_0300);
      check_eq("d_halt_req", req, 0);
      check_eq("d_halt_mis", mis, 1);
    end
    step(1, 1, 32'h0000_0BAD, 0, 0, 0);
    check_eq("d_rst_mis", mis, 0);
    check_eq("d_rst_valid", valid, 0);
    check_eq("d_rst_pc", pc_o, RST_PC);
    check_eq("d_rst_instr", instr, 32'h0000_0013);

    // Random traffic
    halt_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      halt_cnt = m_halt ? halt_cnt + 1 : 0;
      r_rst = ($urandom_range(0, 199) == 0) || (halt_cnt > 4);
      r_rv  = r_rst ? bit'($urandom_range(0, 1)) : (m_req && ($urandom_range(0, 1) == 1));
      r_rd  = $urandom();
      r_st  = ($urandom_range(0, 9) < 6);
      r_dir = ($urandom_range(0, 11) == 0);
      pick  = $urandom_range(0, 19);
      if (pick == 0)      r_rpc = 32'hFFFF_FFFC;
      else if (pick == 1) r_rpc = $urandom() | 32'h1;
      else                r_rpc = $urandom() & ~32'h3;
      step(r_rst, r_rv, r_rd, r_st, r_dir, r_rpc);
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000: fetch address loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port IMem_Req_o  output  1  instruction-memory read request, held until response.
REQ-005 SHALL have port IMem_Addr_o  output  32  word address of the pending request.
REQ-006 SHALL have port IMem_Rsp_Valid_i  input  1  memory response valid; completes the pending request.
REQ-007 SHALL have port IMem_Rsp_Data_i  input  32  instruction word, sampled when IMem_Rsp_Valid_i=1.
REQ-008 SHALL have port Stall_i  input  1  decode stage cannot accept the held instruction.
REQ-009 SHALL have port Redirect_i  input  1  branch/jump taken; overrides the sequential PC.
REQ-010 SHALL have port Redirect_PC_i  input  32  redirect target, sampled when Redirect_i=1.
REQ-011 SHALL have port Instr_o  output  32  held instruction word for the decoder.
REQ-012 SHALL have port OP_o  output  7  opcode for the control decoder, always equal to Instr_o[6:0].
REQ-013 SHALL have port PC_o  output  32  address of Instr_o.
REQ-014 SHALL have port Instr_Valid_o  output  1  Instr_o/PC_o hold a live instruction.
REQ-015 SHALL have port Misalign_o  output  1  sticky flag for a misaligned redirect target.

Function
REQ-016 SHALL implement states IDLE, FETCH, HOLD, FLUSH, HALT, plus an internal 32-bit fetch pointer PC.
REQ-017 IDLE: IMem_Req_o=0; SHALL move to FETCH on the next cycle unconditionally.
REQ-018 FETCH: IMem_Req_o=1, IMem_Addr_o=PC, both held stable until IMem_Rsp_Valid_i.
REQ-019 FETCH with IMem_Rsp_Valid_i=1 and Redirect_i=0: SHALL load Instr_o<=IMem_Rsp_Data_i, PC_o<=PC, Instr_Valid_o<=1, PC<=PC+4, then go to HOLD. Minimum request-to-valid latency is 1 cycle after the response.
REQ-020 HOLD: IMem_Req_o=0; Instr_o, PC_o and Instr_Valid_o=1 SHALL be held while Stall_i=1.
REQ-021 HOLD with Stall_i=0: the instruction is consumed at that edge; Instr_Valid_o<=0; next state FETCH.
REQ-022 Redirect_i=1 with Redirect_PC_i[1:0]==0: PC<=Redirect_PC_i, Instr_Valid_o<=0 in every state except HALT; Redirect_i SHALL take priority over Stall_i.
REQ-023 Redirect in FETCH without a same-cycle response: next state FLUSH.
REQ-024 Redirect in FETCH with a same-cycle response: data SHALL be discarded; next state FETCH.
REQ-025 Redirect in IDLE or HOLD: next state FETCH.
REQ-026 FLUSH: IMem_Req_o=1 at the old address until IMem_Rsp_Valid_i; the response SHALL be discarded; next state FETCH at the new PC.
REQ-027 Redirect_i=1 with Redirect_PC_i[1:0]!=0: Misalign_o<=1, Instr_Valid_o<=0, state HALT; PC is unchanged.
REQ-028 HALT: IMem_Req_o=0 and outputs frozen until reset; Redirect_i SHALL be ignored.
REQ-029 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-030 No more than one request SHALL be outstanding at any time.

Reset
REQ-031 reset=1 SHALL force state IDLE, PC=RESET_PC, PC_o=RESET_PC, Instr_o=32'h0000_0013 (NOP), Instr_Valid_o=0, IMem_Req_o=0, Misalign_o=0.
REQ-032 reset SHALL override all inputs, including mid-request and HALT; any in-flight response arriving while reset=1 SHALL be ignored.

Verification
REQ-033 Reset release, 0-wait memory returning 32'h0000_0033 -> Req at 32'h0040_0000; Instr_Valid_o=1, OP_o=7'h33, PC_o=32'h0040_0000; next fetch at 32'h0040_0004.
REQ-034 Stall_i=1 for 3 cycles in HOLD -> Instr_o and PC_o stable, Req_o=0; after release, next Req at PC_o+4.
REQ-035 Redirect_i to 32'h0040_0100 while a request waits 2 cycles -> FLUSH discards the old response; next Req at 32'h0040_0100.
REQ-036 Redirect_PC_i=32'h0040_0102 -> Misalign_o=1, Req_o=0 permanently; reset clears it.
REQ-037 RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
REQ-038 Redirect_i and Stall_i both asserted in HOLD -> Instr_Valid_o=0 next cycle; Req at the target.
